// File: rtl/me_pkg.sv
// Shared constants, state encoding and strobe payload for the motion-estimation search sequencer.
package me_pkg;

    localparam int unsigned NUM_PE      = 16;
    localparam int unsigned CAND_CYCLES = 256;
    localparam int unsigned CAND_W      = 8;
    localparam int unsigned N_W         = 13;
    localparam int unsigned VEC_W       = 4;
    localparam int unsigned ROW_W       = 5;
    localparam int unsigned ADDR_R_W    = 8;
    localparam int unsigned ADDR_S_W    = 10;

    // Last cycle of the PE0 pixel window and the final drain cycle of RUN
    localparam int unsigned ACTIVE_LAST = NUM_PE * CAND_CYCLES - 1;
    localparam int unsigned LAST_N      = (NUM_PE - 1) * CAND_CYCLES + CAND_CYCLES - 1 + (NUM_PE - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } me_state_e;

    typedef struct packed {
        logic [NUM_PE-1:0] pe_start;
        logic [NUM_PE-1:0] pe_ready;
        logic [VEC_W-1:0]  vector_x;
        logic [VEC_W-1:0]  vector_y;
    } strobe_t;

endpackage

// File: rtl/me_pe_strobe_decode.sv
// Per-PE strobe decode: from the RUN cycle index n, derive each PE's start/ready strobes
// and the candidate vector of the PE whose distortion is ready.
module me_pe_strobe_decode
    import me_pkg::*;
(
    input  logic [N_W-1:0] n,
    output strobe_t        strobe_c
);

    logic [VEC_W-1:0] slot_y [NUM_PE];

    // One compare slice per PE; PE i runs i cycles behind PE0, negative offsets are inactive
    for (genvar i = 0; i < NUM_PE; i++) begin : g_slice
        localparam logic [N_W-1:0] IDX = N_W'(i);
        logic [N_W-1:0] m;
        logic           active;

        assign m      = n - IDX;
        assign active = (n >= IDX) && (m <= N_W'(ACTIVE_LAST));
        assign strobe_c.pe_start[i] = active && (m[CAND_W-1:0] == '0);
        assign strobe_c.pe_ready[i] = active && (m[CAND_W-1:0] == '1);
        assign slot_y[i] = m[CAND_W+VEC_W-1:CAND_W];
    end

    // pe_ready is one-hot, so an OR-mux selects the ready PE's candidate vector
    always_comb begin
        strobe_c.vector_x = '0;
        strobe_c.vector_y = '0;
        for (int unsigned i = 0; i < NUM_PE; i++) begin
            if (strobe_c.pe_ready[i]) begin
                strobe_c.vector_x = strobe_c.vector_x | VEC_W'(i);
                strobe_c.vector_y = strobe_c.vector_y | slot_y[i];
            end
        end
    end

endmodule

// File: rtl/me_search_control.sv
// Full-search motion estimator sequencer: FSM, RUN cycle counter, memory addresses and
// registered PE/comparator strobes. Outputs are computed from the next state so every
// output is a flop that shows the values belonging to the current cycle.
module me_search_control
    import me_pkg::*;
(
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                comp_start,
    output logic [NUM_PE-1:0]   pe_start,
    output logic [NUM_PE-1:0]   pe_ready,
    output logic [VEC_W-1:0]    vector_x,
    output logic [VEC_W-1:0]    vector_y,
    output logic [ADDR_R_W-1:0] address_r,
    output logic [ADDR_S_W-1:0] address_s
);

    me_state_e state, state_nxt;
    logic [N_W-1:0] n, n_nxt;
    strobe_t        strobe_c;

    logic                busy_d, done_d, comp_start_d;
    logic [NUM_PE-1:0]   pe_start_d, pe_ready_d;
    logic [VEC_W-1:0]    vector_x_d, vector_y_d;
    logic [ADDR_R_W-1:0] address_r_d;
    logic [ADDR_S_W-1:0] address_s_d;
    logic [ROW_W-1:0]    row_sum;

    // State and cycle-index registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            n     <= '0;
        end else begin
            state <= state_nxt;
            n     <= n_nxt;
        end
    end

    // Next state and next cycle index; n restarts at 0 on every entry to RUN
    always_comb begin
        state_nxt = state;
        n_nxt     = '0;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_CLEAR;
            ST_CLEAR: state_nxt = ST_RUN;
            ST_RUN: begin
                if (n == N_W'(LAST_N)) state_nxt = ST_DONE;
                else                   n_nxt     = n + N_W'(1);
            end
            ST_DONE:  if (start) state_nxt = ST_CLEAR;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    me_pe_strobe_decode u_decode (
        .n        (n_nxt),
        .strobe_c (strobe_c)
    );

    // Search-window row is candidate row plus pixel row; the 32-wide window stride adds the zero bit
    assign row_sum = ROW_W'(n_nxt[11:8]) + ROW_W'(n_nxt[7:4]);

    // Output values for the upcoming cycle
    always_comb begin
        busy_d       = 1'b0;
        done_d       = 1'b0;
        comp_start_d = 1'b0;
        pe_start_d   = '0;
        pe_ready_d   = '0;
        vector_x_d   = '0;
        vector_y_d   = '0;
        address_r_d  = '0;
        address_s_d  = '0;
        case (state_nxt)
            ST_CLEAR: busy_d = 1'b1;
            ST_RUN: begin
                busy_d       = 1'b1;
                comp_start_d = 1'b1;
                pe_start_d   = strobe_c.pe_start;
                pe_ready_d   = strobe_c.pe_ready;
                vector_x_d   = strobe_c.vector_x;
                vector_y_d   = strobe_c.vector_y;
                if (n_nxt <= N_W'(ACTIVE_LAST)) begin
                    address_r_d = n_nxt[ADDR_R_W-1:0];
                    address_s_d = {row_sum, 1'b0, n_nxt[3:0]};
                end
            end
            ST_DONE: begin
                done_d       = 1'b1;
                comp_start_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            comp_start <= 1'b0;
            pe_start   <= '0;
            pe_ready   <= '0;
            vector_x   <= '0;
            vector_y   <= '0;
            address_r  <= '0;
            address_s  <= '0;
        end else begin
            busy       <= busy_d;
            done       <= done_d;
            comp_start <= comp_start_d;
            pe_start   <= pe_start_d;
            pe_ready   <= pe_ready_d;
            vector_x   <= vector_x_d;
            vector_y   <= vector_y_d;
            address_r  <= address_r_d;
            address_s  <= address_s_d;
        end
    end

endmodule

// File: tb/tb_me_search_control.sv
// Bench for me_search_control: cycle-level reference model of the search schedule,
// randomized start traffic, and a PE/comparator model that finds the best candidate.
module tb_me_search_control;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        busy, done, comp_start;
    logic [15:0] pe_start, pe_ready;
    logic [3:0]  vector_x, vector_y;
    logic [7:0]  address_r;
    logic [9:0]  address_s;

    me_search_control dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .comp_start (comp_start),
        .pe_start   (pe_start),
        .pe_ready   (pe_ready),
        .vector_x   (vector_x),
        .vector_y   (vector_y),
        .address_r  (address_r),
        .address_s  (address_s)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: search phase and RUN cycle index
    typedef enum {M_IDLE, M_CLEAR, M_RUN, M_DONE} mphase_t;
    mphase_t mst;
    int      mn;

    task automatic model_reset();
        mst = M_IDLE;
        mn  = 0;
    endtask

    task automatic model_advance(input logic st);
        case (mst)
            M_IDLE:  if (st) mst = M_CLEAR;
            M_CLEAR: begin mst = M_RUN; mn = 0; end
            M_RUN:   if (mn == 4110) mst = M_DONE; else mn = mn + 1;
            M_DONE:  if (st) begin mst = M_CLEAR; mn = 0; end
        endcase
    endtask

    // Compare every output with what the schedule rules give for the model's current cycle
    task automatic check_all();
        logic [15:0] e_ps, e_pr;
        int e_vx, e_vy, e_ar, e_as, m;
        e_ps = '0; e_pr = '0; e_vx = 0; e_vy = 0; e_ar = 0; e_as = 0;
        if (mst == M_RUN) begin
            for (int i = 0; i < 16; i++) begin
                m = mn - i;
                if (m >= 0 && m <= 4095 && m % 256 == 0) e_ps[i] = 1'b1;
                if (m >= 255 && m <= 4095 && m % 256 == 255) begin
                    e_pr[i] = 1'b1;
                    e_vx = i;
                    e_vy = m / 256;
                end
            end
            if (mn <= 4095) begin
                e_ar = mn % 256;
                e_as = ((mn / 256) + ((mn % 256) / 16)) * 32 + mn % 16;
            end
        end
        check_val("busy",       32'(busy),       32'(mst == M_CLEAR || mst == M_RUN));
        check_val("done",       32'(done),       32'(mst == M_DONE));
        check_val("comp_start", 32'(comp_start), 32'(mst == M_RUN || mst == M_DONE));
        check_val("pe_start",   32'(pe_start),   32'(e_ps));
        check_val("pe_ready",   32'(pe_ready),   32'(e_pr));
        check_val("vector_x",   32'(vector_x),   32'(e_vx));
        check_val("vector_y",   32'(vector_y),   32'(e_vy));
        check_val("address_r",  32'(address_r),  32'(e_ar));
        check_val("address_s",  32'(address_s),  32'(e_as));
    endtask

    // Observed RUN statistics for the current search
    int           pulses, run_cycles;
    logic [255:0] seen;

    task automatic track();
        if (busy && !comp_start) begin
            pulses = 0; run_cycles = 0; seen = '0;
        end else if (busy) begin
            run_cycles++;
            if (pe_ready != 16'h0) begin
                pulses++;
                seen[int'(vector_y) * 16 + int'(vector_x)] = 1'b1;
            end
        end
    endtask

    // PE array + best-distortion comparator: only candidate (7,9) has a low distortion
    logic [7:0] best_dist;
    logic [3:0] motion_x, motion_y;

    function automatic logic [7:0] pe_dist(input logic [3:0] x, input logic [3:0] y);
        return (x == 4'd7 && y == 4'd9) ? 8'h05 : 8'h80;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            best_dist <= 8'hFF; motion_x <= '0; motion_y <= '0;
        end else if (!comp_start) begin
            best_dist <= 8'hFF; motion_x <= '0; motion_y <= '0;
        end else if (pe_ready != 16'h0 && pe_dist(vector_x, vector_y) < best_dist) begin
            best_dist <= pe_dist(vector_x, vector_y);
            motion_x  <= vector_x;
            motion_y  <= vector_y;
        end
    end

    // One clock: drive start, advance the model on the edge, check on the falling edge
    task automatic step(input logic st);
        start = st;
        @(posedge clock);
        if (reset_n) model_advance(st);
        @(negedge clock);
        check_all();
        track();
    endtask

    task automatic check_result(input string tag);
        check_val({tag, "_pulses"},   32'(pulses),     32'd256);
        check_val({tag, "_run_len"},  32'(run_cycles), 32'd4111);
        check_val({tag, "_cover"},    32'(&seen),      32'd1);
        check_val({tag, "_best"},     32'(best_dist),  32'h05);
        check_val({tag, "_motion_x"}, 32'(motion_x),   32'd7);
        check_val({tag, "_motion_y"}, 32'(motion_y),   32'd9);
    endtask

    // One search from a start pulse; optional start noise during CLEAR/RUN; optional abort by reset
    task automatic run_search(input string tag, input bit noise, input int abort_at);
        int   cyc, done_cyc;
        logic st;
        repeat ($urandom_range(1, 5)) step(1'b0);
        step(1'b1);
        cyc = 1; done_cyc = 0;
        for (int k = 0; k < 5000; k++) begin
            if (done) begin done_cyc = cyc; break; end
            if (abort_at >= 0 && mst == M_RUN && mn == abort_at) begin
                reset_n = 1'b0;
                #1;
                model_reset();
                check_all();
                repeat (2) step(1'b0);
                reset_n = 1'b1;
                return;
            end
            st = 1'b0;
            if (noise && (mst == M_CLEAR || mst == M_RUN) && (mn == 100 || $urandom_range(0, 31) == 0))
                st = 1'b1;
            step(st);
            cyc++;
        end
        check_val({tag, "_done_latency"}, 32'(done_cyc), 32'd4113);
        check_result(tag);
        repeat (3) step(1'b0);
        check_val({tag, "_hold_best"},  32'(best_dist), 32'h05);
        check_val({tag, "_hold_mx"},    32'(motion_x),  32'd7);
        check_val({tag, "_hold_my"},    32'(motion_y),  32'd9);
    endtask

    initial begin
        int dl, searches;
        reset_n = 1'b0;
        start   = 1'b0;
        pulses = 0; run_cycles = 0; seen = '0;
        model_reset();

        // Reset, then idle
        repeat (3) step(1'b0);
        reset_n = 1'b1;
        repeat (10) step(1'b0);

        // Single search with ignored start noise, including a start at n=100
        run_search("search1", 1'b1, -1);

        // Search aborted by reset at n=2000, then a clean full search
        run_search("abort", 1'b0, 2000);
        repeat (4) step(1'b0);
        run_search("search3", 1'b1, -1);

        // start held high: back-to-back searches with a single DONE cycle between them
        dl = 0; searches = 0;
        for (int k = 0; k < 8240; k++) begin
            step(1'b1);
            if (done) begin
                if (dl == 0) begin
                    searches++;
                    check_result("b2b");
                end
                dl++;
            end else if (dl > 0) begin
                check_val("b2b_done_len", 32'(dl), 32'd1);
                dl = 0;
            end
        end
        check_val("b2b_searches", 32'(searches), 32'd2);
        repeat (3) step(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
